// File: rtl/store_pkg.sv
// Shared encodings and widths for the store unit.
package store_pkg;

  localparam int unsigned DATA_W = 32;
  // Wait counter holds MEM_LATENCY, legal range 1..7.
  localparam int unsigned CNT_W  = 3;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_WAIT = 3'd1,
    ST_MERGE   = 3'd2,
    ST_WRITE   = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // A request is rejected for size 11, unaligned sw or odd-address sh.
  function automatic logic req_illegal(input logic [1:0] size, input logic [1:0] addr_lo);
    return (size == 2'b11) ||
           ((size == SZ_WORD) && (addr_lo != 2'b00)) ||
           ((size == SZ_HALF) && addr_lo[0]);
  endfunction

endpackage

// File: rtl/store_merge.sv
// Replaces the addressed halfword/byte lane of a memory word with register data.
module store_merge
  import store_pkg::*;
(
  input  logic [DATA_W-1:0] old_word_i,
  input  logic [DATA_W-1:0] reg_data_i,
  input  logic [1:0]        size_i,
  input  logic [1:0]        addr_lo_i,
  output logic [DATA_W-1:0] merged_o
);

  // Little-endian lane select; a word store replaces the whole word.
  always_comb begin
    merged_o = old_word_i;
    case (size_i)
      SZ_WORD: merged_o = reg_data_i;
      SZ_HALF: begin
        if (addr_lo_i[1]) merged_o[31:16] = reg_data_i[15:0];
        else              merged_o[15:0]  = reg_data_i[15:0];
      end
      SZ_BYTE: begin
        case (addr_lo_i)
          2'd0: merged_o[7:0]   = reg_data_i[7:0];
          2'd1: merged_o[15:8]  = reg_data_i[7:0];
          2'd2: merged_o[23:16] = reg_data_i[7:0];
          2'd3: merged_o[31:24] = reg_data_i[7:0];
        endcase
      end
      default: merged_o = old_word_i;
    endcase
  end

endmodule

// File: rtl/store_unit.sv
// Memory-write controller: sw as a single write, sh/sb as read-modify-write.
module store_unit
  import store_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        store_size,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] reg_data,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  output logic              busy,
  output logic              done,
  output logic              align_err
);

  state_e              state_q;
  logic [DATA_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [1:0]          size_q;
  logic [DATA_W-1:0]   merge_q;
  logic [DATA_W-1:0]   merge_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   mem_addr_q;
  logic                mem_wr_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;

  // Merge uses only captured operands, so late input changes cannot leak in.
  store_merge u_merge (
    .old_word_i (mem_rdata),
    .reg_data_i (data_q),
    .size_i     (size_q),
    .addr_lo_i  (addr_q[1:0]),
    .merged_o   (merge_d)
  );

  // Control FSM; outputs are registered alongside the state they belong to.
  // merge_q doubles as the write-data register and is cleared outside WRITE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      size_q     <= '0;
      merge_q    <= '0;
      cnt_q      <= '0;
      mem_addr_q <= '0;
      mem_wr_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      mem_wr_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            addr_q <= addr;
            data_q <= reg_data;
            size_q <= store_size;
            busy_q <= 1'b1;
            if (req_illegal(store_size, addr[1:0])) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else if (store_size == SZ_WORD) begin
              state_q    <= ST_WRITE;
              mem_addr_q <= {addr[DATA_W-1:2], 2'b00};
              merge_q    <= reg_data;
              mem_wr_q   <= 1'b1;
            end else begin
              state_q    <= ST_RD_WAIT;
              mem_addr_q <= {addr[DATA_W-1:2], 2'b00};
              cnt_q      <= CNT_W'(MEM_LATENCY);
            end
          end
        end
        ST_RD_WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= ST_MERGE;
        end
        ST_MERGE: begin
          merge_q    <= merge_d;
          mem_addr_q <= {addr_q[DATA_W-1:2], 2'b00};
          mem_wr_q   <= 1'b1;
          state_q    <= ST_WRITE;
        end
        ST_WRITE: begin
          merge_q    <= '0;
          mem_addr_q <= '0;
          done_q     <= 1'b1;
          state_q    <= ST_DONE;
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = merge_q;
  assign mem_wr    = mem_wr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign align_err = err_q;

endmodule

// File: tb/tb_store_unit.sv
// Bench for store_unit: two instances (latency 1 and 3) share one stimulus stream.
module tb_store_unit;
  import store_pkg::*;

  localparam int NI = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  store_size;
  logic [31:0] addr;
  logic [31:0] reg_data;
  logic [31:0] mem_rdata [NI];
  logic [31:0] mem_addr  [NI];
  logic [31:0] mem_wdata [NI];
  logic        mem_wr    [NI];
  logic        busy      [NI];
  logic        done      [NI];
  logic        align_err [NI];

  int lat [NI] = '{1, 3};

  store_unit #(.MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .store_size(store_size),
    .addr(addr), .reg_data(reg_data), .mem_rdata(mem_rdata[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_wr(mem_wr[0]),
    .busy(busy[0]), .done(done[0]), .align_err(align_err[0])
  );

  store_unit #(.MEM_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start), .store_size(store_size),
    .addr(addr), .reg_data(reg_data), .mem_rdata(mem_rdata[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_wr(mem_wr[1]),
    .busy(busy[1]), .done(done[1]), .align_err(align_err[1])
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Sparse memories; untouched words return an address-derived pattern.
  logic [31:0] mem0 [logic [31:0]];
  logic [31:0] mem1 [logic [31:0]];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] mrd(input int i, input logic [31:0] a);
    if (i == 0) return mem0.exists(a) ? mem0[a] : dflt(a);
    return mem1.exists(a) ? mem1[a] : dflt(a);
  endfunction

  task automatic mwr(input int i, input logic [31:0] a, input logic [31:0] d);
    if (i == 0) mem0[a] = d;
    else        mem1[a] = d;
  endtask

  // Synchronous memory: latency 1 for instance 0, latency 3 for instance 1.
  logic [31:0] p1a, p1b;
  always @(posedge clk) begin
    mem_rdata[0] <= mrd(0, mem_addr[0]);
    p1a          <= mrd(1, mem_addr[1]);
    p1b          <= p1a;
    mem_rdata[1] <= p1b;
    if (mem_wr[0]) mwr(0, mem_addr[0], mem_wdata[0]);
    if (mem_wr[1]) mwr(1, mem_addr[1], mem_wdata[1]);
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input int i, input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s[%0d] cyc=%0d got=%h exp=%h", nm, i, cyc, got, exp);
  endtask

  // Transaction-level reference: one active request per instance, outputs
  // follow from the cycle offset k since acceptance.
  bit          act   [NI];
  int          t0    [NI];
  int          endk  [NI];
  logic [31:0] m_al  [NI];
  logic [31:0] m_wd  [NI];
  bit          m_err [NI];
  bit          chk_en = 1'b0;

  int          wr_cnt    [NI] = '{0, 0};
  int          done_cnt  [NI] = '{0, 0};
  int          err_cnt   [NI] = '{0, 0};
  logic [31:0] last_wd   [NI];
  logic [31:0] last_wa   [NI];
  int          last_wcyc [NI];

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      logic [31:0] e_addr, e_wd, old, mask;
      logic        e_wr, e_busy, e_done, e_err;
      int          k, sh;
      bit          was_idle;
      e_addr = '0; e_wd = '0; e_wr = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
      k = cyc - t0[i];
      if (act[i]) begin
        e_busy = 1'b1;
        if (k == endk[i]) begin
          e_done = 1'b1;
          e_err  = m_err[i];
        end else begin
          e_addr = m_al[i];
          if (k == endk[i] - 1) begin
            e_wr = 1'b1;
            e_wd = m_wd[i];
          end
        end
      end
      if (chk_en) begin
        chk(i, "busy",      32'(busy[i]),      32'(e_busy));
        chk(i, "done",      32'(done[i]),      32'(e_done));
        chk(i, "align_err", 32'(align_err[i]), 32'(e_err));
        chk(i, "mem_wr",    32'(mem_wr[i]),    32'(e_wr));
        chk(i, "mem_addr",  mem_addr[i],       e_addr);
        chk(i, "mem_wdata", mem_wdata[i],      e_wd);
      end
      if (mem_wr[i]) begin
        wr_cnt[i]++;
        last_wd[i]   = mem_wdata[i];
        last_wa[i]   = mem_addr[i];
        last_wcyc[i] = cyc;
      end
      if (done[i]) done_cnt[i]++;
      if (done[i] && align_err[i]) err_cnt[i]++;

      was_idle = !act[i];
      if (act[i] && k == endk[i]) act[i] = 1'b0;
      if (reset) begin
        act[i] = 1'b0;
      end else if (was_idle && start) begin
        act[i]  = 1'b1;
        t0[i]   = cyc;
        m_al[i] = addr & 32'hFFFF_FFFC;
        m_err[i] = (store_size == 2'b11) ||
                   (store_size == SZ_WORD && addr[1:0] != 2'b00) ||
                   (store_size == SZ_HALF && addr[0]);
        if (m_err[i]) begin
          endk[i] = 1;
        end else if (store_size == SZ_WORD) begin
          endk[i] = 2;
          m_wd[i] = reg_data;
        end else begin
          endk[i] = lat[i] + 3;
          old  = mrd(i, m_al[i]);
          sh   = (store_size == SZ_HALF) ? 16 * int'(addr[1]) : 8 * int'(addr[1:0]);
          mask = ((store_size == SZ_HALF) ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
          m_wd[i] = (old & ~mask) | ((reg_data << sh) & mask);
        end
      end
    end
    if (reset) chk_en = 1'b1;
  end

  int t_iss;
  int wr0 [NI];
  int dn0 [NI];
  int er0 [NI];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cy(input int n);
    for (int j = 0; j < n; j++) tick();
  endtask

  task automatic snap();
    for (int i = 0; i < NI; i++) begin
      wr0[i] = wr_cnt[i];
      dn0[i] = done_cnt[i];
      er0[i] = err_cnt[i];
    end
  endtask

  // One-cycle start; operands are scrambled afterwards to prove they were captured.
  task automatic issue(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    store_size = sz;
    addr       = a;
    reg_data   = d;
    start      = 1'b1;
    t_iss      = cyc;
    tick();
    start      = 1'b0;
    addr       = $urandom;
    reg_data   = $urandom;
    store_size = 2'($urandom_range(0, 3));
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    mwr(0, a, d);
    mwr(1, a, d);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; store_size = 2'b00; addr = '0; reg_data = '0;
    wait_cy(2);
    reset = 1'b0;
    tick();

    // Word store.
    snap();
    issue(SZ_WORD, 32'h0000_0200, 32'h0102_0304);
    wait_cy(6);
    for (int i = 0; i < NI; i++) begin
      chk(i, "sw_wdata", last_wd[i], 32'h0102_0304);
      chk(i, "sw_waddr", last_wa[i], 32'h0000_0200);
      chk(i, "sw_wcyc",  32'(last_wcyc[i] - t_iss), 32'd1);
      chk(i, "sw_nwr",   32'(wr_cnt[i] - wr0[i]), 32'd1);
    end

    // Byte store into the top lane.
    preload(32'h0000_0100, 32'hDEAD_BEEF);
    issue(SZ_BYTE, 32'h0000_0103, 32'h1234_56AB);
    wait_cy(8);
    for (int i = 0; i < NI; i++) begin
      chk(i, "sb_wdata", last_wd[i], 32'hABAD_BEEF);
      chk(i, "sb_waddr", last_wa[i], 32'h0000_0100);
      chk(i, "sb_wcyc",  32'(last_wcyc[i] - t_iss), 32'(lat[i] + 2));
    end

    // Halfword stores into both lanes.
    preload(32'h0000_0100, 32'h1122_3344);
    issue(SZ_HALF, 32'h0000_0102, 32'hFFFF_CAFE);
    wait_cy(8);
    for (int i = 0; i < NI; i++) chk(i, "sh_hi_wdata", last_wd[i], 32'hCAFE_3344);
    preload(32'h0000_0100, 32'h1122_3344);
    issue(SZ_HALF, 32'h0000_0100, 32'hFFFF_CAFE);
    wait_cy(8);
    chk(0, "sh_lo_wdata", last_wd[0], 32'h1122_CAFE);
    chk(1, "sh_lo_wdata", last_wd[1], 32'h1122_CAFE);
    chk(0, "sh_wcyc", 32'(last_wcyc[0] - t_iss), 32'd3);
    chk(1, "sh_wcyc", 32'(last_wcyc[1] - t_iss), 32'd5);

    // Illegal requests: rejected, nothing written.
    snap();
    issue(SZ_HALF, 32'h0000_0101, 32'h5555_5555); wait_cy(3);
    issue(SZ_WORD, 32'h0000_0102, 32'h6666_6666); wait_cy(3);
    issue(2'b11,   32'h0000_0100, 32'h7777_7777); wait_cy(3);
    for (int i = 0; i < NI; i++) begin
      chk(i, "ill_nwr",  32'(wr_cnt[i] - wr0[i]),   32'd0);
      chk(i, "ill_ndone", 32'(done_cnt[i] - dn0[i]), 32'd3);
      chk(i, "ill_nerr", 32'(err_cnt[i] - er0[i]),  32'd3);
    end

    // Reset during RD_WAIT aborts; a following sw still works.
    snap();
    issue(SZ_BYTE, 32'h0000_0104, 32'h0000_0099);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_cy(8);
    for (int i = 0; i < NI; i++) begin
      chk(i, "rst_nwr",   32'(wr_cnt[i] - wr0[i]),   32'd0);
      chk(i, "rst_ndone", 32'(done_cnt[i] - dn0[i]), 32'd0);
    end
    issue(SZ_WORD, 32'h0000_0300, 32'hA5A5_0001);
    wait_cy(6);
    for (int i = 0; i < NI; i++) begin
      chk(i, "post_rst_nwr", 32'(wr_cnt[i] - wr0[i]), 32'd1);
      chk(i, "post_rst_wd",  last_wd[i], 32'hA5A5_0001);
    end

    // Starts while busy are ignored (instance 0 picks up the last one once idle).
    preload(32'h0000_0104, 32'h1122_3344);
    snap();
    issue(SZ_BYTE, 32'h0000_0105, 32'h0000_00C3);
    tick();
    issue(SZ_WORD, 32'h0000_0200, 32'hFFFF_FFFF);
    tick();
    issue(SZ_WORD, 32'h0000_0204, 32'hEEEE_EEEE);
    tick();
    issue(SZ_WORD, 32'h0000_0208, 32'hDDDD_DDDD);
    wait_cy(8);
    chk(1, "ign_nwr",   32'(wr_cnt[1] - wr0[1]),   32'd1);
    chk(1, "ign_ndone", 32'(done_cnt[1] - dn0[1]), 32'd1);
    chk(1, "ign_wdata", last_wd[1], 32'h1122_C344);
    chk(0, "ign_nwr",   32'(wr_cnt[0] - wr0[0]),   32'd2);
    chk(0, "ign_wdata", last_wd[0], 32'hDDDD_DDDD);

    // Random traffic with occasional resets, checked by the model every cycle.
    for (int n = 0; n < 1500; n++) begin
      reset      = ($urandom_range(0, 79) == 0);
      start      = ($urandom_range(0, 2) == 0);
      store_size = 2'($urandom_range(0, 3));
      addr       = 32'h0000_0100 + 32'($urandom_range(0, 63));
      reg_data   = $urandom;
      tick();
    end
    reset = 1'b0;
    start = 1'b0;
    wait_cy(12);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
- Memory-write controller for the multicycle datapath. It handles the register-to-memory direction; the write-back mux handles the memory-to-register direction.
- Executes sw/sh/sb. A word store is a single write.
- Halfword and byte stores use read-modify-write: read the aligned word, merge the register lanes into it, write it back.
- Sits between the B register / ALUOut address and the single-port synchronous memory. The control FSM starts it and waits for done.

Parameters:
- MEM_LATENCY, 1, cycles from mem_addr being presented (mem_wr=0) to mem_rdata valid; legal range 1..7.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  one-cycle request, sampled only in IDLE.
- store_size  input  2  00=sw, 01=sh, 10=sb, 11=illegal.
- addr  input  32  byte address (ALUOut).
- reg_data  input  32  store source (B register); sh uses [15:0], sb uses [7:0].
- mem_rdata  input  32  memory read data.
- mem_addr  output  32  word-aligned address {addr_q[31:2],2'b00}; 0 in IDLE.
- mem_wdata  output  32  write data; 0 except in WRITE.
- mem_wr  output  1  memory write strobe, high only in WRITE.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse in DONE.
- align_err  output  1  valid with done; 1 = request rejected, nothing written.

Behaviour:
- Reset:
  - state=IDLE.
  - All outputs 0.
  - Internal addr_q/data_q/size_q/merge_q/wait counter cleared.
  - Reset during any state aborts the operation: mem_wr=0 from the next cycle, and no done is issued.
- Lane mapping is little-endian within the word.
  - Byte lane k = bits [8k+7:8k], with k=addr[1:0].
  - Halfword lane = addr[1] (0 -> [15:0], 1 -> [31:16]).
- States: IDLE, RD_WAIT, MERGE, WRITE, DONE.
- IDLE:
  - On start, capture addr/reg_data/store_size.
  - Illegal request (size 11, sw with addr[1:0]!=0, or sh with addr[0]=1) -> DONE with align_err=1, no memory access.
  - sw -> WRITE.
  - sh/sb -> RD_WAIT, counter loaded with MEM_LATENCY.
- RD_WAIT: mem_addr driven, mem_wr=0; decrement counter; at count 1 -> MERGE.
- MERGE: merge_q = mem_rdata with the selected lane(s) replaced by reg_data low bits; -> WRITE.
- WRITE: mem_wr=1; mem_wdata = data_q (sw) or merge_q (sh/sb); -> DONE.
- DONE: done=1, align_err per request; -> IDLE. A start asserted in DONE is ignored.
- Latency, with start sampled at cycle 0:
  - sw: write at cycle 1, done at cycle 2.
  - sh/sb: write at cycle MEM_LATENCY+2, done at cycle MEM_LATENCY+3. With the default, write at 3, done at 4.
- start while busy is ignored. It is neither queued nor allowed to corrupt captured operands.
- Inputs addr/reg_data/store_size may change after the start cycle; only captured values are used.
- mem_addr is stable from the first non-IDLE cycle through WRITE.
- Exactly one mem_wr pulse per legal request; zero for illegal requests.
- Back-to-back: a new start is accepted in the IDLE cycle immediately after DONE.

Decomposition:
- Shared package store_pkg:
  - Size encodings SZ_WORD=2'b00, SZ_HALF=2'b01, SZ_BYTE=2'b10.
  - State encoding (3-bit constants for IDLE..DONE).
  - Width 32.
- One natural sub-module: store_merge, purely combinational. Inputs: old word, reg_data, size, addr[1:0]; output: merged word. Instantiated once to feed merge_q.

Test Plan:
- sw, addr=0x0000_0200, reg_data=0x0102_0304 -> cycle 1: mem_wr=1, mem_addr=0x200, mem_wdata=0x0102_0304; cycle 2: done=1, align_err=0; no other mem_wr.
- sb, addr=0x0000_0103, reg_data=0x1234_56AB, memory word 0xDEAD_BEEF, MEM_LATENCY=1 -> mem_addr=0x100 in cycles 1-3; cycle 3: mem_wr=1, mem_wdata=0xABAD_BEEF; cycle 4: done.
- sh, addr=0x0000_0102, reg_data=0xFFFF_CAFE, memory 0x1122_3344 -> mem_wdata=0xCAFE_3344. Repeat at addr=0x100 -> 0x1122_CAFE. Repeat with MEM_LATENCY=3 -> write at cycle 5.
- Illegal requests: sh addr=0x101, sw addr=0x102, size 11 -> done at cycle 1 with align_err=1, mem_wr never asserted, busy high for exactly one cycle.
- sb started, then reset asserted in RD_WAIT -> next cycle all outputs 0, state IDLE, no mem_wr, no done. A following sw completes normally.
- start pulsed with different operands during RD_WAIT and DONE -> ignored; the original write value is unchanged and only one done is seen.
